// File: rtl/qed_scheduler_pkg.sv
// Shared types and defaults for the QED duplication sequencer.
package qed_sched_pkg;
   localparam int unsigned CNT_W_DEF    = 6;
   localparam int unsigned MAX_INSN_DEF = 16;

   typedef enum logic [2:0] {
      ORIG  = 3'd0,
      DRAIN = 3'd1,
      DUP   = 3'd2,
      CHECK = 3'd3
   } state_e;
endpackage

// File: rtl/qed_scheduler_if.sv
// Issue/commit handshake and status bundle between the core wrapper and the QED sequencer.
interface qed_scheduler_if
   import qed_sched_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             qed_ena;
   logic             exec_dup;
   logic             issue_valid;
   logic             commit_valid;
   logic             commit_is_dup;
   logic             qed_mode;
   logic             fetch_hold;
   logic [2:0]       sif_state;
   logic [CNT_W-1:0] qed_num_orig;
   logic [CNT_W-1:0] qed_num_dup;
   logic             sif_commit;
   logic             qed_check_valid;
   logic             proto_err;

   modport slave (
      input  qed_ena, exec_dup, issue_valid, commit_valid, commit_is_dup,
      output qed_mode, fetch_hold, sif_state, qed_num_orig, qed_num_dup,
             sif_commit, qed_check_valid, proto_err
   );

   modport master (
      output qed_ena, exec_dup, issue_valid, commit_valid, commit_is_dup,
      input  qed_mode, fetch_hold, sif_state, qed_num_orig, qed_num_dup,
             sif_commit, qed_check_valid, proto_err
   );
endinterface

// File: rtl/qed_scheduler_updown_cnt.sv
// Saturating up/down counter; exposes next value so callers can act on the post-update count.
module qed_updown_cnt #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic [W-1:0] o_cnt_nxt,
   output logic         o_ovf,
   output logic         o_udf
);
   logic [W-1:0] r_cnt;

   always_comb begin
      o_cnt_nxt = r_cnt;
      o_ovf     = 1'b0;
      o_udf     = 1'b0;
      if (i_en && i_inc && !i_dec) begin
         if (r_cnt == '1) o_ovf = 1'b1;
         else             o_cnt_nxt = r_cnt + 1'b1;
      end else if (i_en && i_dec && !i_inc) begin
         if (r_cnt == '0) o_udf = 1'b1;
         else             o_cnt_nxt = r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= o_cnt_nxt;
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/qed_scheduler.sv
// QED round sequencer: original issue, drain, duplicate replay, single-cycle consistency checkpoint.
module qed_scheduler
   import qed_sched_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned MAX_INSN = MAX_INSN_DEF
) (
   input  logic               clk,
   input  logic               rst,
   qed_scheduler_if.slave     bus
);
   localparam logic [CNT_W:0] MAX_V = (CNT_W+1)'(MAX_INSN);

   state_e           r_state;
   logic [CNT_W-1:0] r_num_orig;
   logic [CNT_W-1:0] r_num_dup;
   logic [CNT_W-1:0] r_dup_issued;
   logic             r_proto_err;

   logic [CNT_W-1:0] w_outst;
   logic [CNT_W-1:0] w_outst_nxt;
   logic             w_ovf;
   logic             w_udf;
   logic             w_active;
   logic             w_fetch_hold;
   logic             w_orig_commit;
   logic             w_dup_commit;
   logic [CNT_W-1:0] w_num_dup_nxt;
   logic [CNT_W:0]   w_sum;

   // A disabled block idles in ORIG; a round already past ORIG runs to completion.
   assign w_active      = bus.qed_ena | (r_state != ORIG);
   assign w_orig_commit = bus.commit_valid & ~bus.commit_is_dup;
   assign w_dup_commit  = bus.commit_valid &  bus.commit_is_dup;
   assign w_sum         = {1'b0, r_num_orig} + {1'b0, w_outst};
   assign w_num_dup_nxt = (w_dup_commit && (r_num_dup != r_num_orig)) ? r_num_dup + 1'b1 : r_num_dup;

   qed_updown_cnt #(.W(CNT_W)) u_outst (
      .clk       (clk),
      .rst_n     (rst),
      .i_en      (w_active),
      .i_inc     (bus.issue_valid),
      .i_dec     (bus.commit_valid),
      .o_cnt     (w_outst),
      .o_cnt_nxt (w_outst_nxt),
      .o_ovf     (w_ovf),
      .o_udf     (w_udf)
   );

   always_comb begin
      w_fetch_hold = 1'b1;
      case (r_state)
         ORIG:    w_fetch_hold = (w_sum >= MAX_V);
         DUP:     w_fetch_hold = (r_dup_issued == r_num_orig);
         default: w_fetch_hold = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ORIG;
         r_num_orig   <= '0;
         r_num_dup    <= '0;
         r_dup_issued <= '0;
         r_proto_err  <= 1'b0;
      end else if (w_active) begin
         if (w_ovf || w_udf || (bus.issue_valid && w_fetch_hold))
            r_proto_err <= 1'b1;
         case (r_state)
            ORIG, DRAIN: begin
               if (w_orig_commit && (r_num_orig != '1)) r_num_orig <= r_num_orig + 1'b1;
               if (w_dup_commit) r_proto_err <= 1'b1;
               if (r_state == ORIG) begin
                  if (bus.qed_ena && (bus.exec_dup || (w_sum >= MAX_V)) && (w_sum != '0))
                     r_state <= DRAIN;
               end else if (w_outst_nxt == '0) begin
                  r_state <= DUP;
               end
            end
            DUP: begin
               if (bus.issue_valid && (r_dup_issued != '1)) r_dup_issued <= r_dup_issued + 1'b1;
               if (w_orig_commit) r_proto_err <= 1'b1;
               if (w_dup_commit && (r_num_dup == r_num_orig)) r_proto_err <= 1'b1;
               r_num_dup <= w_num_dup_nxt;
               if ((w_num_dup_nxt == r_num_orig) && (w_outst_nxt == '0))
                  r_state <= CHECK;
            end
            default: begin
               r_state      <= ORIG;
               r_num_orig   <= '0;
               r_num_dup    <= '0;
               r_dup_issued <= '0;
            end
         endcase
      end
   end

   assign bus.qed_mode        = (r_state == DUP);
   assign bus.fetch_hold      = w_fetch_hold;
   assign bus.sif_state       = r_state;
   assign bus.qed_num_orig    = r_num_orig;
   assign bus.qed_num_dup     = r_num_dup;
   assign bus.sif_commit      = (r_state == CHECK);
   assign bus.qed_check_valid = (r_state == CHECK);
   assign bus.proto_err       = r_proto_err;
endmodule

// File: tb/tb_qed_scheduler.sv
// Directed-vector bench for qed_scheduler with hand-computed expectations.
module tb_qed_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   qed_scheduler_if #(.CNT_W(6)) bus ();

   qed_scheduler #(.CNT_W(6), .MAX_INSN(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick(input logic iv, input logic cv, input logic cd, input logic ed);
      bus.issue_valid   = iv;
      bus.commit_valid  = cv;
      bus.commit_is_dup = cd;
      bus.exec_dup      = ed;
      @(posedge clk);
      #1;
      bus.issue_valid   = 1'b0;
      bus.commit_valid  = 1'b0;
      bus.commit_is_dup = 1'b0;
      bus.exec_dup      = 1'b0;
   endtask

   task automatic issue();    tick(1'b1, 1'b0, 1'b0, 1'b0); endtask
   task automatic commit_o(); tick(1'b0, 1'b1, 1'b0, 1'b0); endtask
   task automatic commit_d(); tick(1'b0, 1'b1, 1'b1, 1'b0); endtask
   task automatic exdup();    tick(1'b0, 1'b0, 1'b0, 1'b1); endtask
   task automatic idle();     tick(1'b0, 1'b0, 1'b0, 1'b0); endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      bus.qed_ena       = 1'b1;
      bus.exec_dup      = 1'b0;
      bus.issue_valid   = 1'b0;
      bus.commit_valid  = 1'b0;
      bus.commit_is_dup = 1'b0;
      do_reset();

      chk("rst_state", 32'(bus.sif_state), 0);
      chk("rst_orig", 32'(bus.qed_num_orig), 0);
      chk("rst_dup", 32'(bus.qed_num_dup), 0);
      chk("rst_outs", {bus.qed_mode, bus.fetch_hold, bus.sif_commit, bus.qed_check_valid, bus.proto_err}, 0);

      // Basic round: 3 originals, exec_dup, 3 duplicates.
      repeat (3) issue();
      repeat (3) commit_o();
      chk("t1_num_orig", 32'(bus.qed_num_orig), 3);
      exdup();
      chk("t1_drain", 32'(bus.sif_state), 1);
      chk("t1_drain_hold", 32'(bus.fetch_hold), 1);
      idle();
      chk("t1_dup", 32'(bus.sif_state), 2);
      chk("t1_dup_mode_hold", {bus.qed_mode, bus.fetch_hold}, 2);
      repeat (3) issue();
      chk("t1_dup_hold", 32'(bus.fetch_hold), 1);
      repeat (2) commit_d();
      chk("t1_still_dup", 32'(bus.sif_state), 2);
      commit_d();
      chk("t1_check", 32'(bus.sif_state), 3);
      chk("t1_strobes", {bus.sif_commit, bus.qed_check_valid}, 3);
      chk("t1_num_dup", 32'(bus.qed_num_dup), 3);
      idle();
      chk("t1_back_orig", 32'(bus.sif_state), 0);
      chk("t1_cleared", {bus.qed_num_orig, bus.qed_num_dup}, 0);
      chk("t1_strobe_off", {bus.sif_commit, bus.qed_check_valid}, 0);
      chk("t1_no_err", 32'(bus.proto_err), 0);

      // exec_dup with two originals still outstanding.
      repeat (2) issue();
      exdup();
      chk("t2_drain", 32'(bus.sif_state), 1);
      chk("t2_hold", 32'(bus.fetch_hold), 1);
      commit_o();
      chk("t2_drain_wait", 32'(bus.sif_state), 1);
      commit_o();
      chk("t2_dup", 32'(bus.sif_state), 2);
      chk("t2_num_orig", 32'(bus.qed_num_orig), 2);
      repeat (2) issue();
      repeat (2) commit_d();
      chk("t2_check", 32'(bus.sif_state), 3);
      idle();
      chk("t2_no_err", 32'(bus.proto_err), 0);

      // Replay-cache limit forces the switch.
      repeat (15) issue();
      chk("t3_hold_15", 32'(bus.fetch_hold), 0);
      issue();
      chk("t3_hold_16", 32'(bus.fetch_hold), 1);
      chk("t3_orig_16", 32'(bus.sif_state), 0);
      idle();
      chk("t3_forced_drain", 32'(bus.sif_state), 1);
      repeat (16) commit_o();
      chk("t3_dup", 32'(bus.sif_state), 2);
      chk("t3_num_orig", 32'(bus.qed_num_orig), 16);
      chk("t3_no_err", 32'(bus.proto_err), 0);
      repeat (16) issue();
      chk("t3_dup_hold", 32'(bus.fetch_hold), 1);
      issue();
      chk("t3_17th_err", 32'(bus.proto_err), 1);
      do_reset();
      chk("t3_rst_err", 32'(bus.proto_err), 0);

      // Duplicate commit in ORIG is a sticky protocol error.
      issue();
      commit_d();
      chk("t4_err", 32'(bus.proto_err), 1);
      chk("t4_num_dup", 32'(bus.qed_num_dup), 0);
      issue();
      commit_o();
      exdup();
      idle();
      chk("t4_dup", 32'(bus.sif_state), 2);
      issue();
      commit_d();
      chk("t4_check", {bus.sif_state, bus.sif_commit}, 7);
      chk("t4_err_round", 32'(bus.proto_err), 1);
      idle();
      chk("t4_err_sticky", 32'(bus.proto_err), 1);
      do_reset();
      chk("t4_err_cleared", 32'(bus.proto_err), 0);

      // Asynchronous reset in the middle of DUP.
      repeat (2) issue();
      repeat (2) commit_o();
      exdup();
      idle();
      repeat (2) issue();
      commit_d();
      chk("t5_pre_state", 32'(bus.sif_state), 2);
      chk("t5_pre_dup", 32'(bus.qed_num_dup), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_state", 32'(bus.sif_state), 0);
      chk("t5_async_cnt", {bus.qed_num_orig, bus.qed_num_dup}, 0);
      chk("t5_async_outs", {bus.qed_mode, bus.fetch_hold, bus.sif_commit, bus.qed_check_valid, bus.proto_err}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // exec_dup with nothing issued, then traffic with QED disabled.
      exdup();
      chk("t6_ignored", 32'(bus.sif_state), 0);
      bus.qed_ena = 1'b0;
      issue();
      issue();
      commit_o();
      exdup();
      chk("t6_off_state", 32'(bus.sif_state), 0);
      chk("t6_off_cnt", 32'(bus.qed_num_orig), 0);
      chk("t6_off_strobe", 32'(bus.sif_commit), 0);
      chk("t6_off_err", 32'(bus.proto_err), 0);
      bus.qed_ena = 1'b1;
      exdup();
      chk("t6_nothing_counted", 32'(bus.sif_state), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/qed_scheduler.md
Name: qed_scheduler

Overview:
- Sequencer for the QED duplication datapath: chooses original vs duplicate issue mode, tracks in-flight and committed instruction counts, and defines the consistency checkpoint.
- Drives the mode select of the QED instruction module, plus the sif_commit / qed_check_valid strobes consumed by the formal consistency checks.
- Sits between the fetch/issue stage, the QED replay cache and the commit stage of the core wrapper.

Parameters:
- CNT_W, 6, width of all instruction counters.
- MAX_INSN, 16, QED replay-cache depth; forces the switch to duplicate mode when reached (MAX_INSN < 2**CNT_W).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- qed_ena  in  1  QED transformation enabled; 0 holds block in ORIG, no checks.
- exec_dup  in  1  request to switch to duplicate mode (free/symbolic input in formal).
- issue_valid  in  1  one instruction issued this cycle.
- commit_valid  in  1  one instruction committed this cycle.
- commit_is_dup  in  1  committed instruction targets duplicate registers (x16-x31).
- qed_mode  out  1  0 = issue originals, 1 = replay duplicates from cache.
- fetch_hold  out  1  stall new issue.
- sif_state  out  3  current FSM state encoding.
- qed_num_orig  out  CNT_W  committed originals this round.
- qed_num_dup  out  CNT_W  committed duplicates this round.
- sif_commit  out  1  checkpoint strobe; register file QED-consistent.
- qed_check_valid  out  1  counts matched; consistency check is meaningful.
- proto_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst=0): state ORIG (encoding 0); all counters 0; qed_mode, fetch_hold, sif_commit, qed_check_valid, proto_err = 0. Reset mid-round discards all counts.
- Internal outstanding counter: +1 on issue_valid, -1 on commit_valid, unchanged when both fire.
  - Decrement at 0 sets proto_err.
  - Increment at 2**CNT_W-1 sets proto_err.
  - Counter saturates in both cases.
- Internal dup_issued counter: counts issue_valid while qed_mode=1.
- States:
  - ORIG (0): qed_mode=0.
    - Original commit (commit_valid & ~commit_is_dup) increments qed_num_orig.
    - fetch_hold=1 once qed_num_orig + outstanding >= MAX_INSN.
    - Go to DRAIN when qed_ena & (exec_dup | qed_num_orig+outstanding >= MAX_INSN) & (qed_num_orig+outstanding) > 0.
    - exec_dup with nothing issued is ignored.
  - DRAIN (1): fetch_hold=1, qed_mode=0.
    - Originals keep committing and counting.
    - Go to DUP when outstanding==0, including the cycle the last commit lands: use the post-update value.
  - DUP (2): qed_mode=1.
    - fetch_hold=1 once dup_issued == qed_num_orig.
    - Duplicate commit increments qed_num_dup.
    - Go to CHECK when qed_num_dup (post-update) == qed_num_orig and outstanding (post-update) == 0.
  - CHECK (3): single cycle; sif_commit=1, qed_check_valid=1, fetch_hold=1.
    - Next cycle: ORIG with qed_num_orig, qed_num_dup and dup_issued cleared.
- Protocol errors (set proto_err, state unaffected, proto_err cleared only by reset):
  - Original commit in DUP, or duplicate commit in ORIG/DRAIN.
  - Duplicate commit when qed_num_dup == qed_num_orig.
  - issue_valid while fetch_hold=1.
- qed_ena=0: block stays in ORIG, no counting, strobes 0. Deassertion mid-round completes the round.
- Simultaneous events: a commit in the same cycle as a transition is counted under the pre-transition state.
- qed_num_orig/qed_num_dup never wrap; MAX_INSN bounds them.
- All outputs are registered or decoded from state/counters only; no input-to-output combinational path.

Decomposition:
- Package qed_sched_pkg:
  - state enum: ORIG=0, DRAIN=1, DUP=2, CHECK=3.
  - CNT_W default.
  - MAX_INSN default.
- Sub-module qed_updown_cnt: saturating up/down counter with over/underflow flags, used for outstanding.
- FSM and round counters stay in qed_scheduler.

Test Plan:
- 3 issues then 3 original commits, exec_dup at cycle 5 -> DRAIN then DUP; after 3 dup issues and 3 dup commits, CHECK for exactly 1 cycle with sif_commit=qed_check_valid=1; next cycle counts 0, state ORIG.
- exec_dup with 2 originals still outstanding -> fetch_hold=1 in DRAIN until both commit; DUP entered the cycle after the last commit; qed_num_orig=2.
- 16 originals issued without exec_dup -> fetch_hold asserts at 16 and forced switch to DUP occurs; 17th issue_valid attempt -> proto_err=1.
- Duplicate commit while in ORIG -> proto_err=1 and sticky; stays 1 through a full round until rst low.
- Async reset asserted while in DUP with qed_num_dup=1 -> all outputs 0 immediately, state ORIG, no clock edge needed.
- exec_dup with zero issued and qed_ena=0 during traffic -> state remains ORIG, counters stay 0, sif_commit never pulses.
